// File: rtl/microcode_pkg.sv
// rtl/microcode_pkg.sv - shared loader state type and default store geometry
package microcode_pkg;

    // Defaults shared with the microcode store instance
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_SIZE       = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs an MSB-first byte stream into words
module byte_word_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  word_last_o,
    output logic [DATA_WIDTH-1:0] word_next_o,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  word_valid_q;

    // New bytes enter at the LSB side, so the first byte of a word ends up on top
    assign word_next_o  = (shift_q << 8) | DATA_WIDTH'(byte_i);
    assign word_last_o  = byte_valid_i && (idx_q == IDX_W'(BPW - 1));
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    // Shift/index state; completed word is registered and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= word_last_o;
            if (clear_i) begin
                idx_q   <= '0;
                shift_q <= '0;
            end else if (byte_valid_i) begin
                shift_q <= word_next_o;
                if (word_last_o) begin
                    idx_q  <= '0;
                    word_q <= word_next_o;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/microcode_loader.sv
// rtl/microcode_loader.sv - byte-stream loader writing words into the microcode store
module microcode_loader
    import microcode_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    loader_state_e         state_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] checksum_q;

    logic                  start_accept;
    logic [CNT_W-1:0]      count_d;
    logic                  byte_accept;
    logic                  word_last;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  last_word;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign count_d      = (word_count > CNT_W'(SIZE)) ? CNT_W'(SIZE) : word_count;
    assign byte_accept  = in_valid && (state_q == LOAD);
    assign last_word    = ({1'b0, word_idx_q} == (count_q - CNT_W'(1)));

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD) || (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign wr_addr  = wr_addr_q;
    assign checksum = checksum_q;

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_accept),
        .byte_valid_i (byte_accept),
        .byte_i       (in_data),
        .word_last_o  (word_last),
        .word_next_o  (word_next),
        .word_valid_o (wr_enable),
        .word_o       (wr_data)
    );

    // Load FSM: word index, write address and checksum advance with each completed word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            wr_addr_q  <= '0;
            checksum_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_accept) begin
                        checksum_q <= '0;
                        word_idx_q <= '0;
                        count_q    <= count_d;
                        state_q    <= (count_d == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (word_last) begin
                        checksum_q <= checksum_q + word_next;
                        wr_addr_q  <= word_idx_q;
                        if (last_word) begin
                            state_q <= FLUSH;
                        end else begin
                            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
